// File: rtl/csr_file_m.sv
// Machine-mode CSR file: decoded CSR ops, trap entry and mret, interrupt arbitration,
// U/M privilege and retire counters, with a registered one-cycle fetch redirect.
module csr_file_m #(
    parameter int              XLEN     = 64,
    parameter int              CNT_W    = 64,
    parameter int              RETIRE_W = 2,
    parameter logic [XLEN-1:0] HARTID   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         csr_raddr,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                csr_rillegal,
    input  logic                csr_we,
    input  logic [11:0]         csr_waddr,
    input  logic [1:0]          csr_wop,
    input  logic [XLEN-1:0]     csr_wsrc,
    input  logic [RETIRE_W-1:0] instret_inc,
    input  logic                trap_valid,
    input  logic                trap_is_irq,
    input  logic [5:0]          trap_cause,
    input  logic [XLEN-1:0]     trap_pc,
    input  logic [XLEN-1:0]     trap_tval,
    input  logic                mret_valid,
    input  logic                ext_msip,
    input  logic                ext_mtip,
    input  logic                ext_meip,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                irq_req,
    output logic [5:0]          irq_cause,
    output logic [1:0]          priv_mode,
    output logic [XLEN-1:0]     mstatus_out,
    output logic [XLEN-1:0]     mtvec_out,
    output logic [XLEN-1:0]     mepc_out,
    output logic [XLEN-1:0]     mcause_out,
    output logic [XLEN-1:0]     mtval_out,
    output logic [XLEN-1:0]     mip_out,
    output logic [XLEN-1:0]     mie_out,
    output logic [XLEN-1:0]     mscratch_out,
    output logic [XLEN-1:0]     mcycle_out,
    output logic [XLEN-1:0]     minstret_out,
    output logic [XLEN-1:0]     satp_out
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_SATP     = 12'h180;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [1:0]  PRIV_M     = 2'b11;
    localparam logic [1:0]  PRIV_U     = 2'b00;
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

    logic             mstatus_mie_reg, mstatus_mpie_reg;
    logic [1:0]       mstatus_mpp_reg, priv_mode_reg;
    logic [XLEN-1:0]  mtvec_reg, mepc_reg, mcause_reg, mtval_reg;
    logic [XLEN-1:0]  mie_reg, mscratch_reg, satp_reg;
    logic [CNT_W-1:0] mcycle_reg, minstret_reg;
    logic             msip_reg, mtip_reg, meip_reg;
    logic             redirect_valid_reg;
    logic [XLEN-1:0]  redirect_pc_reg;

    logic [XLEN-1:0]  mstatus_vec, mip_vec;
    logic [XLEN:0]    rd_lookup, wr_lookup;
    logic [XLEN-1:0]  wold, wnew, mtvec_base, trap_target;
    logic             wen, irq_en, pend_ms, pend_mt, pend_me;

    always_comb begin
        mstatus_vec        = '0;
        mstatus_vec[3]     = mstatus_mie_reg;
        mstatus_vec[7]     = mstatus_mpie_reg;
        mstatus_vec[12:11] = mstatus_mpp_reg;
    end

    assign mip_vec = XLEN'({meip_reg, 3'b000, mtip_reg, 3'b000, msip_reg, 3'b000});

    // Returns {implemented, value} for an address; shared by the read port and the op datapath.
    function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
        logic [XLEN:0] r;
        case (addr)
            A_MSTATUS:  r = {1'b1, mstatus_vec};
            A_MIE:      r = {1'b1, mie_reg};
            A_MTVEC:    r = {1'b1, mtvec_reg};
            A_MSCRATCH: r = {1'b1, mscratch_reg};
            A_MEPC:     r = {1'b1, mepc_reg};
            A_MCAUSE:   r = {1'b1, mcause_reg};
            A_MTVAL:    r = {1'b1, mtval_reg};
            A_MIP:      r = {1'b1, mip_vec};
            A_SATP:     r = {1'b1, satp_reg};
            A_MCYCLE:   r = {1'b1, XLEN'(mcycle_reg)};
            A_MINSTRET: r = {1'b1, XLEN'(minstret_reg)};
            A_MHARTID:  r = {1'b1, HARTID};
            default:    r = '0;
        endcase
        return r;
    endfunction

    assign rd_lookup    = csr_lookup(csr_raddr);
    assign csr_rdata    = rd_lookup[XLEN-1:0];
    assign csr_rillegal = ~rd_lookup[XLEN];
    assign wr_lookup    = csr_lookup(csr_waddr);
    assign wold         = wr_lookup[XLEN-1:0];

    always_comb begin
        case (csr_wop)
            2'b01:   wnew = csr_wsrc;
            2'b10:   wnew = wold | csr_wsrc;
            2'b11:   wnew = wold & ~csr_wsrc;
            default: wnew = wold;
        endcase
    end

    // A trap or mret in the same cycle swallows the CSR op.
    assign wen = csr_we && (csr_wop != 2'b00) && wr_lookup[XLEN] && !trap_valid && !mret_valid;

    assign mtvec_base  = mtvec_reg & ~XLEN'(3);
    assign trap_target = (mtvec_reg[0] && trap_is_irq) ? mtvec_base + XLEN'({trap_cause, 2'b00})
                                                       : mtvec_base;

    assign irq_en  = (priv_mode_reg == PRIV_U) || ((priv_mode_reg == PRIV_M) && mstatus_mie_reg);
    assign pend_ms = msip_reg & mie_reg[3];
    assign pend_mt = mtip_reg & mie_reg[7];
    assign pend_me = meip_reg & mie_reg[11];
    assign irq_req = irq_en & (pend_ms | pend_mt | pend_me);

    always_comb begin
        if (pend_me)      irq_cause = 6'd11;
        else if (pend_ms) irq_cause = 6'd3;
        else if (pend_mt) irq_cause = 6'd7;
        else              irq_cause = 6'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_mie_reg    <= 1'b0;
            mstatus_mpie_reg   <= 1'b0;
            mstatus_mpp_reg    <= PRIV_U;
            priv_mode_reg      <= PRIV_M;
            mtvec_reg          <= '0;
            mepc_reg           <= '0;
            mcause_reg         <= '0;
            mtval_reg          <= '0;
            mie_reg            <= '0;
            mscratch_reg       <= '0;
            satp_reg           <= '0;
            mcycle_reg         <= '0;
            minstret_reg       <= '0;
            msip_reg           <= 1'b0;
            mtip_reg           <= 1'b0;
            meip_reg           <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            msip_reg           <= ext_msip;
            mtip_reg           <= ext_mtip;
            meip_reg           <= ext_meip;
            mcycle_reg         <= mcycle_reg + CNT_W'(1);
            minstret_reg       <= minstret_reg + CNT_W'(instret_inc);
            redirect_valid_reg <= 1'b0;
            if (trap_valid) begin
                mepc_reg           <= trap_pc & ~XLEN'(3);
                mcause_reg         <= {trap_is_irq, {(XLEN-7){1'b0}}, trap_cause};
                mtval_reg          <= trap_tval;
                mstatus_mpie_reg   <= mstatus_mie_reg;
                mstatus_mie_reg    <= 1'b0;
                mstatus_mpp_reg    <= priv_mode_reg;
                priv_mode_reg      <= PRIV_M;
                redirect_valid_reg <= 1'b1;
                redirect_pc_reg    <= trap_target;
            end else if (mret_valid) begin
                mstatus_mie_reg    <= mstatus_mpie_reg;
                mstatus_mpie_reg   <= 1'b1;
                priv_mode_reg      <= mstatus_mpp_reg;
                mstatus_mpp_reg    <= PRIV_U;
                redirect_valid_reg <= 1'b1;
                redirect_pc_reg    <= mepc_reg;
            end else if (wen) begin
                // Counter writes land after the increments above, so the write wins.
                case (csr_waddr)
                    A_MSTATUS: begin
                        mstatus_mie_reg  <= wnew[3];
                        mstatus_mpie_reg <= wnew[7];
                        if (wnew[12:11] == PRIV_U || wnew[12:11] == PRIV_M)
                            mstatus_mpp_reg <= wnew[12:11];
                    end
                    A_MIE:      mie_reg      <= wnew & MIE_MASK;
                    A_MTVEC:    mtvec_reg    <= wnew & ~XLEN'(2);
                    A_MSCRATCH: mscratch_reg <= wnew;
                    A_MEPC:     mepc_reg     <= wnew & ~XLEN'(3);
                    A_MCAUSE:   mcause_reg   <= wnew;
                    A_MTVAL:    mtval_reg    <= wnew;
                    A_SATP:     satp_reg     <= wnew;
                    A_MCYCLE:   mcycle_reg   <= CNT_W'(wnew);
                    A_MINSTRET: minstret_reg <= CNT_W'(wnew);
                    default: ;
                endcase
            end
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign priv_mode      = priv_mode_reg;
    assign mstatus_out    = mstatus_vec;
    assign mtvec_out      = mtvec_reg;
    assign mepc_out       = mepc_reg;
    assign mcause_out     = mcause_reg;
    assign mtval_out      = mtval_reg;
    assign mip_out        = mip_vec;
    assign mie_out        = mie_reg;
    assign mscratch_out   = mscratch_reg;
    assign mcycle_out     = XLEN'(mcycle_reg);
    assign minstret_out   = XLEN'(minstret_reg);
    assign satp_out       = satp_reg;
endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: expected values are queued with each stimulus and
// popped when the corresponding DUT state becomes visible.
module tb_csr_file_m;
    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] csr_raddr = '0;
    logic [63:0] csr_rdata;
    logic        csr_rillegal;
    logic        csr_we = 1'b0;
    logic [11:0] csr_waddr = '0;
    logic [1:0]  csr_wop = '0;
    logic [63:0] csr_wsrc = '0;
    logic [1:0]  instret_inc = '0;
    logic        trap_valid = 1'b0;
    logic        trap_is_irq = 1'b0;
    logic [5:0]  trap_cause = '0;
    logic [63:0] trap_pc = '0;
    logic [63:0] trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        ext_msip = 1'b0, ext_mtip = 1'b0, ext_meip = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        irq_req;
    logic [5:0]  irq_cause;
    logic [1:0]  priv_mode;
    logic [63:0] mstatus_out, mtvec_out, mepc_out, mcause_out, mtval_out, mip_out;
    logic [63:0] mie_out, mscratch_out, mcycle_out, minstret_out, satp_out;

    always #5 clk = ~clk;

    csr_file_m dut (
        .clk(clk), .reset(reset),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rillegal(csr_rillegal),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wop(csr_wop), .csr_wsrc(csr_wsrc),
        .instret_inc(instret_inc),
        .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
        .ext_msip(ext_msip), .ext_mtip(ext_mtip), .ext_meip(ext_meip),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_req(irq_req), .irq_cause(irq_cause), .priv_mode(priv_mode),
        .mstatus_out(mstatus_out), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
        .mcause_out(mcause_out), .mtval_out(mtval_out), .mip_out(mip_out),
        .mie_out(mie_out), .mscratch_out(mscratch_out), .mcycle_out(mcycle_out),
        .minstret_out(minstret_out), .satp_out(satp_out)
    );

    task automatic expect_val(input string n, input logic [63:0] v);
        exp_t t;
        t.name = n;
        t.val  = v;
        exp_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] src);
        csr_we = 1'b1; csr_wop = op; csr_waddr = addr; csr_wsrc = src;
        step();
        csr_we = 1'b0; csr_wop = 2'b00;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        #2 reset = 1'b0;
        expect_val("reset_mcycle", 64'd0);
        expect_val("reset_priv", 64'd3);
        expect_val("reset_redirect_valid", 64'd0);
        expect_val("reset_irq_req", 64'd0);
        expect_val("reset_mstatus", 64'd0);
        step(); step();
        e = exp_q.pop_front(); n_total++;
        if (mcycle_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcycle_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (irq_req !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_req, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        reset = 1'b1;
        expect_val("idle10_mcycle", 64'd10);
        expect_val("idle10_minstret", 64'd0);
        expect_val("idle10_priv", 64'd3);
        repeat (10) step();
        e = exp_q.pop_front(); n_total++;
        if (mcycle_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcycle_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (minstret_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, minstret_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
    endtask

    task automatic test_reads();
        exp_t e;
        expect_val("sstatus_rdata", 64'd0);
        expect_val("sstatus_illegal", 64'd1);
        csr_raddr = 12'h100; #1;
        e = exp_q.pop_front(); n_total++;
        if (csr_rdata !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rdata, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (csr_rillegal !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rillegal, e.val); else n_pass++;
        expect_val("mhartid_after_write", 64'd0);
        expect_val("mhartid_legal", 64'd0);
        csr_op(2'b01, 12'hF14, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_raddr = 12'hF14; #1;
        e = exp_q.pop_front(); n_total++;
        if (csr_rdata !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rdata, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (csr_rillegal !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rillegal, e.val); else n_pass++;
    endtask

    task automatic test_mstatus();
        exp_t e;
        csr_raddr = 12'h300;
        expect_val("mstatus_write_ones", 64'h1888);
        csr_op(2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        e = exp_q.pop_front(); n_total++;
        if (csr_rdata !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rdata, e.val); else n_pass++;
        expect_val("mstatus_no_bypass", 64'h1888);
        expect_val("mstatus_clear_mie", 64'h1880);
        csr_we = 1'b1; csr_wop = 2'b11; csr_waddr = 12'h300; csr_wsrc = 64'h8;
        #1;
        e = exp_q.pop_front(); n_total++;
        if (csr_rdata !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rdata, e.val); else n_pass++;
        step();
        csr_we = 1'b0; csr_wop = 2'b00;
        e = exp_q.pop_front(); n_total++;
        if (csr_rdata !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, csr_rdata, e.val); else n_pass++;
        expect_val("mstatus_bad_mpp_kept", 64'h1800);
        csr_op(2'b01, 12'h300, 64'h1000);
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
    endtask

    task automatic test_trap_irq();
        exp_t e;
        expect_val("mtvec_bit1_forced", 64'h8000_0001);
        csr_op(2'b01, 12'h305, 64'h8000_0003);
        e = exp_q.pop_front(); n_total++;
        if (mtvec_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mtvec_out, e.val); else n_pass++;
        expect_val("mie_mask", 64'h888);
        csr_op(2'b01, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
        e = exp_q.pop_front(); n_total++;
        if (mie_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mie_out, e.val); else n_pass++;
        csr_op(2'b01, 12'h304, 64'h80);
        expect_val("mstatus_set_mie", 64'h1808);
        expect_val("irq_same_cycle", 64'd0);
        csr_op(2'b10, 12'h300, 64'h8);
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        ext_mtip = 1'b1; #1;
        e = exp_q.pop_front(); n_total++;
        if (irq_req !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_req, e.val); else n_pass++;
        expect_val("mtip_irq_req", 64'd1);
        expect_val("mtip_irq_cause", 64'd7);
        expect_val("mtip_mip", 64'h80);
        step();
        e = exp_q.pop_front(); n_total++;
        if (irq_req !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_req, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (irq_cause !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_cause, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mip_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mip_out, e.val); else n_pass++;
        trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 6'd7;
        trap_pc = 64'h8000_0104; trap_tval = 64'h0; ext_mtip = 1'b0;
        expect_val("irq_trap_redirect_valid", 64'd1);
        expect_val("irq_trap_redirect_pc", 64'h8000_001C);
        expect_val("irq_trap_mepc", 64'h8000_0104);
        expect_val("irq_trap_mcause", 64'h8000_0000_0000_0007);
        expect_val("irq_trap_mstatus", 64'h1880);
        expect_val("irq_trap_redirect_drop", 64'd0);
        step();
        trap_valid = 1'b0; trap_is_irq = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mepc_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mepc_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mcause_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcause_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        step();
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
    endtask

    task automatic test_mret();
        exp_t e;
        mret_valid = 1'b1;
        expect_val("mret_redirect_valid", 64'd1);
        expect_val("mret_redirect_pc", 64'h8000_0104);
        expect_val("mret_mstatus", 64'h88);
        expect_val("mret_priv", 64'd3);
        step();
        mret_valid = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
    endtask

    task automatic test_user_irq();
        exp_t e;
        expect_val("mstatus_mpp1_rejected", 64'h0);
        csr_op(2'b01, 12'h300, 64'h800);
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        mret_valid = 1'b1;
        expect_val("mret_to_user_priv", 64'd0);
        expect_val("mret_to_user_mstatus", 64'h80);
        step();
        mret_valid = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        csr_op(2'b01, 12'h304, 64'h888);
        ext_msip = 1'b1; ext_meip = 1'b1;
        expect_val("user_irq_req", 64'd1);
        expect_val("prio_meip_over_msip", 64'd11);
        expect_val("prio_msip_over_mtip", 64'd3);
        expect_val("prio_mtip_alone", 64'd7);
        step();
        e = exp_q.pop_front(); n_total++;
        if (irq_req !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_req, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (irq_cause !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_cause, e.val); else n_pass++;
        ext_meip = 1'b0; ext_mtip = 1'b1;
        step();
        e = exp_q.pop_front(); n_total++;
        if (irq_cause !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_cause, e.val); else n_pass++;
        ext_msip = 1'b0;
        step();
        e = exp_q.pop_front(); n_total++;
        if (irq_cause !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_cause, e.val); else n_pass++;
        trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 6'd2;
        trap_pc = 64'h2003; trap_tval = 64'hDEAD;
        expect_val("exc_redirect_pc_direct", 64'h8000_0000);
        expect_val("exc_mepc_aligned", 64'h2000);
        expect_val("exc_mcause", 64'd2);
        expect_val("exc_mtval", 64'hDEAD);
        expect_val("exc_mstatus_mpp_user", 64'h0);
        expect_val("exc_priv", 64'd3);
        expect_val("exc_irq_masked", 64'd0);
        step();
        trap_valid = 1'b0; ext_mtip = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mepc_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mepc_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mcause_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcause_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mtval_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mtval_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (irq_req !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, irq_req, e.val); else n_pass++;
    endtask

    task automatic test_priority();
        exp_t e;
        expect_val("mscratch_write", 64'h1234);
        csr_op(2'b01, 12'h340, 64'h1234);
        e = exp_q.pop_front(); n_total++;
        if (mscratch_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mscratch_out, e.val); else n_pass++;
        trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 6'd3; trap_pc = 64'h3000; trap_tval = 64'h0;
        mret_valid = 1'b1;
        csr_we = 1'b1; csr_wop = 2'b01; csr_waddr = 12'h340; csr_wsrc = 64'h55;
        expect_val("all3_mscratch_kept", 64'h1234);
        expect_val("all3_mcause_trap", 64'd3);
        expect_val("all3_mstatus_trap", 64'h1800);
        expect_val("all3_redirect_pc", 64'h8000_0000);
        step();
        trap_valid = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (mscratch_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mscratch_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mcause_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcause_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        csr_wsrc = 64'h66;
        expect_val("mret_csr_mscratch_kept", 64'h1234);
        expect_val("b2b_redirect_valid", 64'd1);
        expect_val("b2b_redirect_pc_mepc", 64'h3000);
        expect_val("mret_csr_mstatus", 64'h80);
        step();
        mret_valid = 1'b0; csr_we = 1'b0; csr_wop = 2'b00;
        e = exp_q.pop_front(); n_total++;
        if (mscratch_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mscratch_out, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mstatus_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mstatus_out, e.val); else n_pass++;
        expect_val("mepc_write_aligned", 64'h1234);
        csr_op(2'b01, 12'h341, 64'h1237);
        e = exp_q.pop_front(); n_total++;
        if (mepc_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mepc_out, e.val); else n_pass++;
    endtask

    task automatic test_counters();
        exp_t e;
        expect_val("mcycle_write_wins", 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("mcycle_wrap", 64'd0);
        csr_op(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        e = exp_q.pop_front(); n_total++;
        if (mcycle_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcycle_out, e.val); else n_pass++;
        step();
        e = exp_q.pop_front(); n_total++;
        if (mcycle_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mcycle_out, e.val); else n_pass++;
        instret_inc = 2'd3;
        expect_val("minstret_write_wins", 64'd100);
        csr_op(2'b01, 12'hB02, 64'd100);
        e = exp_q.pop_front(); n_total++;
        if (minstret_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, minstret_out, e.val); else n_pass++;
        instret_inc = 2'd0;
        csr_op(2'b01, 12'hB02, 64'd0);
        expect_val("minstret_inc3_x2", 64'd6);
        instret_inc = 2'd3;
        step(); step();
        instret_inc = 2'd0;
        e = exp_q.pop_front(); n_total++;
        if (minstret_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, minstret_out, e.val); else n_pass++;
    endtask

    task automatic test_reset_redirect();
        exp_t e;
        trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 6'd1; trap_pc = 64'h5000;
        expect_val("rst_mid_redirect_valid", 64'd0);
        expect_val("rst_mid_redirect_pc", 64'd0);
        expect_val("rst_mid_mepc", 64'd0);
        expect_val("rst_after_redirect_valid", 64'd0);
        expect_val("rst_after_priv", 64'd3);
        #3 reset = 1'b0;
        step();
        trap_valid = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (redirect_pc !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_pc, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (mepc_out !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, mepc_out, e.val); else n_pass++;
        reset = 1'b1;
        step();
        e = exp_q.pop_front(); n_total++;
        if (redirect_valid !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, redirect_valid, e.val); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (priv_mode !== e.val) $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, priv_mode, e.val); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reads();
        test_mstatus();
        test_trap_irq();
        test_mret();
        test_user_irq();
        test_priority();
        test_counters();
        test_reset_redirect();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
